// File: rtl/depacketizer_pkg.sv
// Shared definitions for the two-flit depacketizer.
// Provides flit field offsets, payload split widths and the FIFO entry layout.
package depacketizer_pkg;

    // Per-flit header bit positions, counted from the flit LSB (flit width f).
    function automatic int flit_valid_pos(input int f);
        return f - 1;
    endfunction

    function automatic int flit_head_pos(input int f);
        return f - 2;
    endfunction

    function automatic int flit_tail_pos(input int f);
        return f - 3;
    endfunction

    function automatic int flit_vc_lsb(input int f, input int vw);
        return f - 3 - vw;
    endfunction

    // Only flit 1 carries dest; data1 follows it.
    function automatic int flit_dest_lsb(input int f, input int aw, input int vw);
        return f - 3 - vw - aw;
    endfunction

    function automatic int flit1_data_msb(input int f, input int aw, input int vw);
        return f - 4 - vw - aw;
    endfunction

    function automatic int flit2_data_msb(input int f, input int vw);
        return f - 4 - vw;
    endfunction

    // Data capacity of each flit.
    function automatic int flit1_idl(input int f, input int aw, input int vw);
        return f - 3 - aw - vw;
    endfunction

    function automatic int flit2_idl(input int f, input int vw);
        return f - 3 - vw;
    endfunction

    // Payload spills into flit 2 only when it does not fit in flit 1.
    function automatic bit two_flit(input int wo, input int f, input int aw, input int vw);
        return wo > flit1_idl(f, aw, vw);
    endfunction

    // Entry layout for the default configuration; the top builds the same
    // layout sized from its own parameters.
    localparam int unsigned DEF_WIDTH_OUT        = 12;
    localparam int unsigned DEF_ADDRESS_WIDTH    = 4;
    localparam int unsigned DEF_VC_ADDRESS_WIDTH = 1;

    typedef struct packed {
        logic [DEF_WIDTH_OUT-1:0]        payload;
        logic [DEF_ADDRESS_WIDTH-1:0]    dest;
        logic [DEF_VC_ADDRESS_WIDTH-1:0] vc;
    } pkt_entry_t;

endpackage

// File: rtl/pkt_fifo_2.sv
// Two-entry FIFO with a registered ready.
// Ports: clk, rst (sync, active-high), push/push_data, pop, head_data (head
// entry register), valid (count > 0), ready (count < 2, registered).
module pkt_fifo_2 #(
    parameter int unsigned ENTRY_W = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head_data,
    output logic               valid,
    output logic               ready
);
    logic [1:0]         count_q, count_d;
    logic [ENTRY_W-1:0] head_q, head_d;
    logic [ENTRY_W-1:0] tail_q, tail_d;
    logic               ready_q, ready_d;
    logic               do_push, do_pop;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        do_push = push && ready_q;
        do_pop  = pop && (count_q != 2'd0);
        if (do_push && do_pop) begin
            // ready_q excludes count 2, so count is 1 here: replace the head.
            head_d = push_data;
        end else if (do_push) begin
            if (count_q == 2'd0) begin
                head_d = push_data;
            end else begin
                tail_d = push_data;
            end
            count_d = count_q + 2'd1;
        end else if (do_pop) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end
        ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
        end
    end

    assign head_data = head_q;
    assign valid     = (count_q != 2'd0);
    assign ready     = ready_q;

endmodule

// File: rtl/depacketizer_2.sv
// Receive-side depacketizer for two-flit NoC packets.
// Checks flit headers, extracts {payload, dest, vc} from well-formed packets
// into a 2-entry FIFO, and drops malformed packets with a sticky error flag and
// a saturating drop counter.
// Ports: clk, rst (sync, active-high); i_data_in/i_valid_in/i_ready_out NoC
// side; o_data_out/o_dest_out/o_vc_out/o_valid_out/o_ready_in consumer side;
// o_err, o_err_count status.
module depacketizer_2
    import depacketizer_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH    = 4,
    parameter int unsigned VC_ADDRESS_WIDTH = 1,
    parameter int unsigned WIDTH_IN         = 36,
    parameter int unsigned WIDTH_OUT        = 12,
    parameter int unsigned ERR_CNT_WIDTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_IN-1:0]         i_data_in,
    input  logic                        i_valid_in,
    output logic                        i_ready_out,
    output logic [WIDTH_OUT-1:0]        o_data_out,
    output logic [ADDRESS_WIDTH-1:0]    o_dest_out,
    output logic [VC_ADDRESS_WIDTH-1:0] o_vc_out,
    output logic                        o_valid_out,
    input  logic                        o_ready_in,
    output logic                        o_err,
    output logic [ERR_CNT_WIDTH-1:0]    o_err_count
);
    localparam int F        = WIDTH_IN / 2;
    localparam int AW       = ADDRESS_WIDTH;
    localparam int VW       = VC_ADDRESS_WIDTH;
    localparam int F1_IDL   = flit1_idl(F, AW, VW);
    localparam bit TWO_FL   = two_flit(WIDTH_OUT, F, AW, VW);
    localparam int P1       = (WIDTH_OUT < F1_IDL) ? WIDTH_OUT : F1_IDL;
    localparam int VLD_POS  = flit_valid_pos(F);
    localparam int HEAD_POS = flit_head_pos(F);
    localparam int TAIL_POS = flit_tail_pos(F);
    localparam int VC_LSB   = flit_vc_lsb(F, VW);
    localparam int DST_LSB  = flit_dest_lsb(F, AW, VW);
    localparam int D1_MSB   = flit1_data_msb(F, AW, VW);
    localparam int D2_MSB   = flit2_data_msb(F, VW);

    typedef struct packed {
        logic [WIDTH_OUT-1:0]        payload;
        logic [ADDRESS_WIDTH-1:0]    dest;
        logic [VC_ADDRESS_WIDTH-1:0] vc;
    } entry_t;

    logic [F-1:0]         flit1, flit2;
    logic [WIDTH_OUT-1:0] payload;
    logic                 accept, well_formed, push;
    entry_t               push_entry, head_entry;
    logic                 fifo_ready;
    logic                 err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 unused_bits;

    assign flit1 = i_data_in[2*F-1:F];
    assign flit2 = i_data_in[F-1:0];

    // Pad bits and, in single-flit mode, flit 2 data go unused.
    assign unused_bits = ^{flit1, flit2};

    if (TWO_FL) begin : g_two_flit
        localparam int P2 = WIDTH_OUT - F1_IDL;
        assign payload = {flit1[D1_MSB -: P1], flit2[D2_MSB -: P2]};
    end else begin : g_one_flit
        assign payload = flit1[D1_MSB -: P1];
    end

    always_comb begin
        well_formed = flit1[HEAD_POS] && (flit1[TAIL_POS] == !TWO_FL);
        if (TWO_FL) begin
            well_formed = well_formed && flit2[VLD_POS] && !flit2[HEAD_POS] && flit2[TAIL_POS]
                          && (flit2[VC_LSB +: VW] == flit1[VC_LSB +: VW]);
        end else begin
            well_formed = well_formed && !flit2[VLD_POS];
        end
    end

    // Words with flit 1 invalid are idle slots and never count as errors.
    assign accept = i_valid_in && fifo_ready && flit1[VLD_POS];
    assign push   = accept && well_formed;

    assign push_entry.payload = payload;
    assign push_entry.dest    = flit1[DST_LSB +: AW];
    assign push_entry.vc      = flit1[VC_LSB +: VW];

    pkt_fifo_2 #(
        .ENTRY_W ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (o_ready_in),
        .head_data (head_entry),
        .valid     (o_valid_out),
        .ready     (fifo_ready)
    );

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (accept && !well_formed) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign i_ready_out = fifo_ready;
    assign o_data_out  = head_entry.payload;
    assign o_dest_out  = head_entry.dest;
    assign o_vc_out    = head_entry.vc;
    assign o_err       = err_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_depacketizer_2.sv
// Directed self-checking bench for depacketizer_2 (default parameters).
module tb_depacketizer_2;
    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] i_data_in;
    logic        i_valid_in;
    logic        i_ready_out;
    logic [11:0] o_data_out;
    logic [3:0]  o_dest_out;
    logic [0:0]  o_vc_out;
    logic        o_valid_out;
    logic        o_ready_in;
    logic        o_err;
    logic [7:0]  o_err_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    depacketizer_2 dut (
        .clk         (clk),
        .rst         (rst),
        .i_data_in   (i_data_in),
        .i_valid_in  (i_valid_in),
        .i_ready_out (i_ready_out),
        .o_data_out  (o_data_out),
        .o_dest_out  (o_dest_out),
        .o_vc_out    (o_vc_out),
        .o_valid_out (o_valid_out),
        .o_ready_in  (o_ready_in),
        .o_err       (o_err),
        .o_err_count (o_err_count)
    );

    // Flit 1 = {1,1,0,vc,dest,p[11:2]}, flit 2 = {1,0,1,vc,p[1:0],12'b0}.
    function automatic logic [35:0] mk(input logic [11:0] p, input logic [3:0] d, input logic v);
        logic [17:0] f1, f2;
        f1 = {3'b110, v, d, p[11:2]};
        f2 = {3'b101, v, p[1:0], 12'h000};
        return {f1, f2};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid_in = 1'b0; i_data_in = '0; o_ready_in = 1'b1;
        step(); step();
        rst = 1'b0;
        vectors++;
        if (o_valid_out !== 1'b0 || i_ready_out !== 1'b1 || o_err !== 1'b0 ||
            o_err_count !== 8'd0 || o_data_out !== 12'h000 || o_dest_out !== 4'h0 ||
            o_vc_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: valid=%b ready=%b err=%b cnt=%0d data=%h dest=%h vc=%b, need 0 1 0 0 000 0 0",
                     o_valid_out, i_ready_out, o_err, o_err_count, o_data_out, o_dest_out, o_vc_out);
        end
    endtask

    task automatic test_single();
        vectors++;
        if (mk(12'hABC, 4'd5, 1'b0) !== 36'hC5ABE8000) begin
            miscompares++;
            $display("FAIL word_build: got %h need C5ABE8000", mk(12'hABC, 4'd5, 1'b0));
        end
        i_data_in = 36'hC5ABE8000; i_valid_in = 1'b1; o_ready_in = 1'b1;
        step();
        i_valid_in = 1'b0;
        vectors++;
        if (o_valid_out !== 1'b1 || o_data_out !== 12'hABC || o_dest_out !== 4'd5 ||
            o_vc_out !== 1'b0 || o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL single: valid=%b data=%h dest=%0d vc=%b err=%b, need 1 abc 5 0 0",
                     o_valid_out, o_data_out, o_dest_out, o_vc_out, o_err);
        end
        step();
        vectors++;
        if (o_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL single_one_cycle: valid=%b need 0", o_valid_out);
        end
        i_data_in = mk(12'h5A3, 4'hA, 1'b1); i_valid_in = 1'b1;
        step();
        i_valid_in = 1'b0;
        vectors++;
        if (o_valid_out !== 1'b1 || o_data_out !== 12'h5A3 || o_dest_out !== 4'hA ||
            o_vc_out !== 1'b1) begin
            miscompares++;
            $display("FAIL single_vc1: valid=%b data=%h dest=%h vc=%b, need 1 5a3 a 1",
                     o_valid_out, o_data_out, o_dest_out, o_vc_out);
        end
        step();
    endtask

    task automatic test_back_to_back();
        o_ready_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            i_data_in = mk(12'(i), 4'd3, 1'b0); i_valid_in = 1'b1;
            step();
            vectors++;
            if (o_valid_out !== 1'b1 || o_data_out !== 12'(i) || i_ready_out !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b[%0d]: valid=%b data=%h ready=%b, need 1 %h 1",
                         i, o_valid_out, o_data_out, i_ready_out, 12'(i));
            end
        end
        i_valid_in = 1'b0;
        step();
        vectors++;
        if (o_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: valid=%b need 0", o_valid_out);
        end
    endtask

    task automatic test_backpressure();
        o_ready_in = 1'b0;
        i_data_in = mk(12'h001, 4'd1, 1'b0); i_valid_in = 1'b1;
        step();
        vectors++;
        if (i_ready_out !== 1'b1 || o_valid_out !== 1'b1 || o_data_out !== 12'h001) begin
            miscompares++;
            $display("FAIL bp_first: ready=%b valid=%b data=%h, need 1 1 001",
                     i_ready_out, o_valid_out, o_data_out);
        end
        i_data_in = mk(12'h002, 4'd1, 1'b0);
        step();
        vectors++;
        if (i_ready_out !== 1'b0 || o_data_out !== 12'h001) begin
            miscompares++;
            $display("FAIL bp_full: ready=%b data=%h, need 0 001", i_ready_out, o_data_out);
        end
        i_data_in = mk(12'h003, 4'd1, 1'b0);
        step();
        vectors++;
        if (i_ready_out !== 1'b0 || o_valid_out !== 1'b1 || o_data_out !== 12'h001) begin
            miscompares++;
            $display("FAIL bp_hold: ready=%b valid=%b data=%h, need 0 1 001",
                     i_ready_out, o_valid_out, o_data_out);
        end
        o_ready_in = 1'b1;
        step();
        vectors++;
        if (o_valid_out !== 1'b1 || o_data_out !== 12'h002 || i_ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_second: valid=%b data=%h ready=%b, need 1 002 1",
                     o_valid_out, o_data_out, i_ready_out);
        end
        step();
        i_valid_in = 1'b0;
        vectors++;
        if (o_valid_out !== 1'b1 || o_data_out !== 12'h003) begin
            miscompares++;
            $display("FAIL bp_third: valid=%b data=%h, need 1 003", o_valid_out, o_data_out);
        end
        step();
        vectors++;
        if (o_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_empty: valid=%b need 0", o_valid_out);
        end
    endtask

    task automatic test_idle();
        i_data_in = '0; i_valid_in = 1'b1;
        step(); step();
        i_valid_in = 1'b0;
        vectors++;
        if (o_valid_out !== 1'b0 || o_err !== 1'b0 || o_err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL idle: valid=%b err=%b cnt=%0d, need 0 0 0", o_valid_out, o_err, o_err_count);
        end
    endtask

    task automatic test_malformed();
        i_data_in = 36'hC5ABC8000; i_valid_in = 1'b1;
        step();
        i_valid_in = 1'b0;
        vectors++;
        if (o_valid_out !== 1'b0 || o_err !== 1'b1 || o_err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL malformed: valid=%b err=%b cnt=%0d, need 0 1 1", o_valid_out, o_err, o_err_count);
        end
        // Single-flit style header (tail set in flit 1) is also malformed.
        i_data_in = 36'hC5ABE8000 | (36'h1 << 33); i_valid_in = 1'b1;
        step();
        i_valid_in = 1'b0;
        vectors++;
        if (o_valid_out !== 1'b0 || o_err_count !== 8'd2) begin
            miscompares++;
            $display("FAIL malformed_tail1: valid=%b cnt=%0d, need 0 2", o_valid_out, o_err_count);
        end
        i_data_in = 36'hC5ABE8000; i_valid_in = 1'b1;
        step();
        i_valid_in = 1'b0;
        vectors++;
        if (o_valid_out !== 1'b1 || o_data_out !== 12'hABC || o_err !== 1'b1 || o_err_count !== 8'd2) begin
            miscompares++;
            $display("FAIL good_after_bad: valid=%b data=%h err=%b cnt=%0d, need 1 abc 1 2",
                     o_valid_out, o_data_out, o_err, o_err_count);
        end
        step();
    endtask

    task automatic test_saturate();
        i_data_in = 36'hC5ABC8000; i_valid_in = 1'b1;
        for (int i = 0; i < 300; i++) step();
        i_valid_in = 1'b0;
        vectors++;
        if (o_err_count !== 8'd255 || o_err !== 1'b1 || o_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL saturate: cnt=%0d err=%b valid=%b, need 255 1 0", o_err_count, o_err, o_valid_out);
        end
    endtask

    task automatic test_midstream_reset();
        o_ready_in = 1'b0;
        i_data_in = mk(12'h111, 4'd2, 1'b0); i_valid_in = 1'b1;
        step();
        i_data_in = mk(12'h222, 4'd2, 1'b0);
        step();
        vectors++;
        if (o_valid_out !== 1'b1 || i_ready_out !== 1'b0) begin
            miscompares++;
            $display("FAIL mr_fill: valid=%b ready=%b, need 1 0", o_valid_out, i_ready_out);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; i_valid_in = 1'b0;
        vectors++;
        if (o_valid_out !== 1'b0 || i_ready_out !== 1'b1 || o_err !== 1'b0 ||
            o_err_count !== 8'd0 || o_data_out !== 12'h000 || o_dest_out !== 4'h0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b ready=%b err=%b cnt=%0d data=%h dest=%h, need 0 1 0 0 000 0",
                     o_valid_out, i_ready_out, o_err, o_err_count, o_data_out, o_dest_out);
        end
        o_ready_in = 1'b1;
        step();
        vectors++;
        if (o_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL mr_discard: valid=%b need 0", o_valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_idle();
        test_malformed();
        test_saturate();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
